// File: rtl/cla_5bit_nand_only_if.sv
// rtl/cla_5bit_nand_only_if.sv - operand and result bundle for the 5-bit NAND-only CLA
interface cla_5bit_nand_only_if;
   logic [4:0] a_in;
   logic [4:0] b_in;
   logic       cin;
   logic [4:0] sum;
   logic       cout;

   modport master (
      output a_in,
      output b_in,
      output cin,
      input  sum,
      input  cout
   );

   modport slave (
      input  a_in,
      input  b_in,
      input  cin,
      output sum,
      output cout
   );
endinterface

// File: rtl/cla_5bit_nand_only.sv
// rtl/cla_5bit_nand_only.sv - two-stage registered 5-bit carry-lookahead adder built only from 2-input NANDs
module cla_5bit_nand_only (
   input  logic                    clk,
   input  logic                    rst,
   cla_5bit_nand_only_if.slave     io
);

   logic [4:0] a;
   logic [4:0] b;
   logic       c0;
   logic [4:0] sum_comb;
   logic       cout_comb;

   logic [4:0] p;
   logic [4:0] g;
   logic [5:0] carry;

   // Every gate below bottoms out in nd(); nothing else touches the add path.
   function automatic logic nd(input logic x, input logic y);
      return ~(x & y);
   endfunction

   function automatic logic inv(input logic x);
      return nd(x, x);
   endfunction

   function automatic logic and2(input logic x, input logic y);
      return inv(nd(x, y));
   endfunction

   function automatic logic or2(input logic x, input logic y);
      return nd(inv(x), inv(y));
   endfunction

   function automatic logic xor2(input logic x, input logic y);
      logic m;
      m = nd(x, y);
      return nd(nd(x, m), nd(y, m));
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         a  <= '0;
         b  <= '0;
         c0 <= 1'b0;
      end else begin
         a  <= io.a_in;
         b  <= io.b_in;
         c0 <= io.cin;
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         p[i] = xor2(a[i], b[i]);
         g[i] = and2(a[i], b[i]);
      end
   end

   // Each carry is a flat sum of products over p/g/c0; no carry feeds another.
   always_comb begin
      logic acc;
      logic prod;
      carry    = '0;
      carry[0] = c0;
      for (int i = 0; i < 5; i++) begin
         acc  = g[i];
         prod = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = or2(acc, and2(prod, g[j]));
            prod = and2(prod, p[j]);
         end
         acc          = or2(acc, and2(prod, c0));
         carry[i + 1] = acc;
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         sum_comb[i] = xor2(p[i], carry[i]);
      end
      cout_comb = carry[5];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io.sum  <= '0;
         io.cout <= 1'b0;
      end else begin
         io.sum  <= sum_comb;
         io.cout <= cout_comb;
      end
   end

endmodule

// File: tb/tb_cla_5bit_nand_only.sv
// tb/tb_cla_5bit_nand_only.sv - self-checking bench for the 5-bit NAND-only CLA
module tb_cla_5bit_nand_only;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;
   int   cycle;

   cla_5bit_nand_only_if bus ();

   cla_5bit_nand_only dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic       c;
      logic [4:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   typedef struct {
      logic [5:0] exp;
      int         due;
      string      name;
   } sb_t;

   vec_t vecs[7];
   sb_t  sb[$];

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b required %b", name, act, exp);
   endtask

   task automatic drain();
      sb_t e;
      while (sb.size() > 0 && sb[0].due <= cycle) begin
         e = sb.pop_front();
         check(e.name, {bus.cout, bus.sum}, e.exp);
      end
   endtask

   task automatic stream_step(input logic [4:0] av, input logic [4:0] bv, input logic cv, input string name);
      sb_t e;
      bus.a_in = av;
      bus.b_in = bv;
      bus.cin  = cv;
      e.exp  = {1'b0, av} + {1'b0, bv} + {5'b0, cv};
      e.due  = cycle + 2;
      e.name = name;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drain();
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      cycle     = 0;
      rst       = 1'b1;
      bus.a_in  = 5'b10101;
      bus.b_in  = 5'b00000;
      bus.cin   = 1'b0;

      vecs[0] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
      vecs[1] = '{5'b00001, 5'b00001, 1'b0, 5'b00010, 1'b0};
      vecs[2] = '{5'b01111, 5'b00001, 1'b0, 5'b10000, 1'b0};
      vecs[3] = '{5'b10101, 5'b01010, 1'b0, 5'b11111, 1'b0};
      vecs[4] = '{5'b11111, 5'b11111, 1'b0, 5'b11110, 1'b1};
      vecs[5] = '{5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b1};
      vecs[6] = '{5'b10101, 5'b01010, 1'b1, 5'b00000, 1'b1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_a",        {1'b0, dut.a}, 6'd0);
      check("reset_b",        {1'b0, dut.b}, 6'd0);
      check("reset_c0",       {5'b0, dut.c0}, 6'd0);
      check("reset_comb",     {dut.cout_comb, dut.sum_comb}, 6'd0);
      check("reset_out",      {bus.cout, bus.sum}, 6'd0);

      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         bus.a_in = vecs[k].a;
         bus.b_in = vecs[k].b;
         bus.cin  = vecs[k].c;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_comb", k), {dut.cout_comb, dut.sum_comb},
               {vecs[k].exp_cout, vecs[k].exp_sum});
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_out", k), {bus.cout, bus.sum},
               {vecs[k].exp_cout, vecs[k].exp_sum});
      end

      // Back-to-back operands; output lags two edges behind the sampled inputs.
      stream_step(5'b00011, 5'b00100, 1'b0, "pipe0");
      check("pipe_hold_prev", {bus.cout, bus.sum}, 6'b100000);
      stream_step(5'b11111, 5'b00001, 1'b0, "pipe1");
      stream_step(5'b01010, 5'b00101, 1'b0, "pipe2");
      bus.a_in = 5'b00000;
      bus.b_in = 5'b00000;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         drain();
      end
      check("pipe_sb_empty", {5'b0, sb.size() == 0}, 6'd1);

      bus.a_in = 5'b11111;
      bus.b_in = 5'b11111;
      bus.cin  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midflight_rst_out", {bus.cout, bus.sum}, 6'd0);
      rst      = 1'b0;
      bus.a_in = 5'b00000;
      bus.b_in = 5'b00000;
      @(posedge clk);
      @(negedge clk);
      check("midflight_no_stale", {bus.cout, bus.sum}, 6'd0);
      @(posedge clk);
      @(negedge clk);
      check("midflight_after", {bus.cout, bus.sum}, 6'd0);

      for (int n = 0; n < 2048; n++) begin
         logic [10:0] idx;
         idx = n[10:0];
         stream_step(idx[4:0], idx[9:5], idx[10], $sformatf("exh_%0d", n));
      end
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         drain();
      end
      check("exh_sb_empty", {5'b0, sb.size() == 0}, 6'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
